// File: rtl/siganfu_barrel_thermal_monitor.sv
// Barrel heat model: integrates heat per round, bleeds it off while idle, and drives
// overheat_sensor back to the gun with hysteresis, a warning flag and a sticky fault.
module siganfu_barrel_thermal_monitor #(
    parameter int unsigned HEAT_W        = 10,
    parameter int unsigned HEAT_PER_SHOT = 4,
    parameter int unsigned HEAT_MAX      = 1023,
    parameter int unsigned WARN_THRESH   = 80,
    parameter int unsigned HOT_THRESH    = 100,
    parameter int unsigned COOL_THRESH   = 40,
    parameter int unsigned COOL_DIV      = 2,
    parameter int unsigned COOL_STEP     = 1,
    parameter int unsigned FAULT_SHOTS   = 3
) (
    input  logic              sysclk,
    input  logic              reboot,
    input  logic              fire_trigger,
    output logic              overheat_sensor,
    output logic              heat_warning,
    output logic [HEAT_W-1:0] heat_level,
    output logic [1:0]        thermal_state,
    output logic              sensor_fault
);

    localparam int unsigned PS_W = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam int unsigned SC_W = (FAULT_SHOTS > 0) ? $clog2(FAULT_SHOTS + 1) : 1;

    localparam logic [HEAT_W:0]   MAX_X  = (HEAT_W+1)'(HEAT_MAX);
    localparam logic [HEAT_W:0]   INC_X  = (HEAT_W+1)'(HEAT_PER_SHOT);
    localparam logic [HEAT_W-1:0] MAX_H  = HEAT_W'(HEAT_MAX);
    localparam logic [HEAT_W-1:0] STEP_H = HEAT_W'(COOL_STEP);
    localparam logic [HEAT_W-1:0] WARN_H = HEAT_W'(WARN_THRESH);
    localparam logic [HEAT_W-1:0] HOT_H  = HEAT_W'(HOT_THRESH);
    localparam logic [HEAT_W-1:0] COOL_H = HEAT_W'(COOL_THRESH);
    localparam logic [PS_W-1:0]   PS_END = PS_W'(COOL_DIV - 1);
    localparam logic [SC_W-1:0]   SC_MAX = SC_W'(FAULT_SHOTS);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_WARM   = 2'd1,
        ST_HOT    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    logic [HEAT_W-1:0] r_heat;
    logic [PS_W-1:0]   r_pre;
    logic [SC_W-1:0]   r_shots;
    state_t            r_state;

    logic [HEAT_W:0]   w_sum;
    logic [HEAT_W-1:0] w_heat_next;
    logic [PS_W-1:0]   w_pre_next;
    logic [SC_W-1:0]   w_shots_inc;
    logic [SC_W-1:0]   w_shots_next;
    state_t            w_state_next;

    // Heat integration: a shot always wins over a coincident cooling tick.
    always_comb begin
        w_sum       = {1'b0, r_heat} + INC_X;
        w_heat_next = r_heat;
        w_pre_next  = r_pre;
        if (fire_trigger) begin
            w_heat_next = (w_sum > MAX_X) ? MAX_H : w_sum[HEAT_W-1:0];
            w_pre_next  = '0;
        end else if (r_pre == PS_END) begin
            w_pre_next  = '0;
            w_heat_next = (r_heat < STEP_H) ? '0 : r_heat - STEP_H;
        end else begin
            w_pre_next  = r_pre + PS_W'(1);
        end
    end

    // Thermal state transitions; HOT holds until heat falls to COOL_THRESH.
    always_comb begin
        w_shots_inc  = (r_shots == SC_MAX) ? r_shots : r_shots + SC_W'(1);
        w_shots_next = r_shots;
        w_state_next = r_state;
        case (r_state)
            ST_NORMAL, ST_WARM: begin
                w_shots_next = '0;
                if (w_heat_next >= HOT_H) begin
                    w_state_next = ST_HOT;
                end else if (w_heat_next >= WARN_H) begin
                    w_state_next = ST_WARM;
                end else begin
                    w_state_next = ST_NORMAL;
                end
            end
            ST_HOT: begin
                if (fire_trigger) begin
                    w_shots_next = w_shots_inc;
                end
                if (fire_trigger && (w_shots_inc == SC_MAX)) begin
                    w_state_next = ST_FAULT;
                end else if (w_heat_next <= COOL_H) begin
                    w_state_next = ST_NORMAL;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reboot) begin
        if (reboot) begin
            r_heat          <= '0;
            r_pre           <= '0;
            r_shots         <= '0;
            r_state         <= ST_NORMAL;
            heat_warning    <= 1'b0;
            overheat_sensor <= 1'b0;
            sensor_fault    <= 1'b0;
        end else begin
            r_heat          <= w_heat_next;
            r_pre           <= w_pre_next;
            r_shots         <= w_shots_next;
            r_state         <= w_state_next;
            heat_warning    <= (w_heat_next >= WARN_H);
            overheat_sensor <= (w_state_next == ST_HOT) || (w_state_next == ST_FAULT);
            sensor_fault    <= (w_state_next == ST_FAULT);
        end
    end

    assign heat_level    = r_heat;
    assign thermal_state = r_state;

endmodule
